// File: rtl/fsqrt_issue.sv
`default_nettype none
// ============================================================================
//  Module      : fsqrt_core / fsqrt_issue
//  Description : fsqrt_core is a combinational IEEE-754 single-precision
//                square root with round-to-nearest-even. fsqrt_issue wraps it
//                in a valid/ready issue/result stage. It holds the captured
//                operand stable for LATENCY cycles (a declared multicycle
//                path), then registers the result with its tag and flags.
//  Ports (fsqrt_issue):
//      clk, rst            clock, asynchronous active-high reset
//      in_valid/in_ready   operand handshake; in_x operand, in_tag tag
//      out_valid/out_ready result handshake
//      out_y               square root of the accepted operand
//      out_tag             tag of the operand that produced out_y
//      out_flags           {nv, nan_in}
//  Revision    : 1.0 - initial release
// ============================================================================

module fsqrt_core (
    input  logic [31:0] x,
    output logic [31:0] y
);
    logic        w_sgn;
    logic [7:0]  w_exp;
    logic [22:0] w_man;

    assign w_sgn = x[31];
    assign w_exp = x[30:23];
    assign w_man = x[22:0];

    logic [23:0] w_sig;
    logic [8:0]  w_sum;
    logic [24:0] w_rad_m;
    logic [49:0] w_rad;
    logic [27:0] w_rem;
    logic [27:0] w_trial;
    logic [24:0] w_root;
    logic        w_rnd;
    logic [31:0] w_norm;

    always_comb begin
        // Significand with hidden bit; subnormals are normalised below.
        w_sig = {(w_exp != 8'd0), w_man};
        // w_sum = biased exponent + 127. Result exponent is w_sum/2 and an odd
        // w_sum means the unbiased exponent is odd, so the radicand doubles.
        w_sum = 9'd127 + ((w_exp == 8'd0) ? 9'd1 : {1'b0, w_exp});
        for (int i = 0; i < 23; i++) begin
            if (!w_sig[23]) begin
                w_sig = w_sig << 1;
                w_sum = w_sum - 9'd1;
            end
        end
        w_rad_m = w_sum[0] ? {w_sig, 1'b0} : {1'b0, w_sig};
        w_rad   = {w_rad_m, 25'd0};

        // Restoring digit-by-digit integer square root: 25 result bits,
        // 24 significant plus one round bit; the remainder gives sticky.
        w_rem   = 28'd0;
        w_root  = 25'd0;
        w_trial = 28'd0;
        for (int i = 24; i >= 0; i--) begin
            w_rem   = {w_rem[25:0], w_rad[2*i +: 2]};
            w_trial = {1'b0, w_root, 2'b01};
            if (w_rem >= w_trial) begin
                w_rem  = w_rem - w_trial;
                w_root = {w_root[23:0], 1'b1};
            end else begin
                w_root = {w_root[23:0], 1'b0};
            end
        end
        w_rnd = w_root[0] & ((w_rem != 28'd0) | w_root[1]);

        // Hidden bit (w_root[24]) adds into the exponent field, so the
        // exponent is pre-decremented; a rounding carry also propagates.
        w_norm = {1'b0, w_sum[8:1] - 8'd1, 23'd0}
               + {8'd0, w_root[24:1]}
               + {31'd0, w_rnd};

        if (w_exp == 8'hFF && w_man != 23'd0)
            y = {w_sgn, 8'hFF, 1'b1, w_man[21:0]};      // quiet NaN, keep payload
        else if (w_sgn && x[30:0] != 31'd0)
            y = 32'hFFC0_0000;                          // negative -> default NaN
        else if (x[30:0] == 31'd0 || w_exp == 8'hFF)
            y = x;                                      // +-0, +inf
        else
            y = w_norm;
    end
endmodule

module fsqrt_issue #(
    parameter int LATENCY = 4,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_flags
);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        op_q, op_d;
    logic [TAG_W-1:0]   op_tag_q, op_tag_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_y_q, out_y_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic [1:0]         out_flags_q, out_flags_d;

    logic [31:0] w_core_y;
    logic        w_accept;
    logic        w_special;
    logic        w_nan_in;
    logic        w_nv;

    fsqrt_core u_core (
        .x (op_q),
        .y (w_core_y)
    );

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_special = (in_x[30:0] == 31'd0) | (in_x[30:23] == 8'hFF) | in_x[31];

    assign w_nan_in = (op_q[30:23] == 8'hFF) & (op_q[22:0] != 23'd0);
    assign w_nv     = (w_nan_in & ~op_q[22])
                    | (op_q[31] & (op_q[30:0] != 31'd0) & ~w_nan_in);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        op_tag_d    = op_tag_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_tag_d   = out_tag_q;
        out_flags_d = out_flags_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    out_y_d     = w_core_y;
                    out_tag_d   = op_tag_q;
                    out_flags_d = {w_nv, w_nan_in};
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = w_accept ? S_WAIT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Operand capture shared by the IDLE and DONE accept paths.
        if (w_accept) begin
            op_d     = in_x;
            op_tag_d = in_tag;
            cnt_d    = w_special ? '0 : CNT_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            op_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_tag_q   <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            op_tag_q    <= op_tag_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_tag_q   <= out_tag_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_tag   = out_tag_q;
    assign out_flags = out_flags_q;
endmodule

`default_nettype wire

// File: tb/tb_fsqrt_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsqrt_issue
//  Description : Self-checking bench for fsqrt_issue. Table vectors stream
//                through a scoreboard queue; hand sequences cover
//                backpressure with same-cycle drain/accept and reset aborts.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_fsqrt_issue;
    localparam int LAT = 4;
    localparam int TW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_x = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_y;
    logic [TW-1:0] out_tag;
    logic [1:0]    out_flags;

    fsqrt_issue #(.LATENCY(LAT), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   x;
        logic [TW-1:0] tag;
        logic [31:0]   y;
        logic [1:0]    fl;
        int            lat;
    } vec_t;

    typedef struct {
        logic [31:0]   y;
        logic [TW-1:0] tag;
        logic [1:0]    fl;
        int            acc;
        int            lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_bad  = 0;
    logic prev_v = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitor: push on accept, pop on drain, latency on rise.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_bad++;
                    $display("FAIL spurious_valid: got out_valid=1 with y=%h, want no result", out_y);
                end else begin
                    chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                end
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_y", out_y, e.y);
                chk("out_tag", 32'(out_tag), 32'(e.tag));
                chk("out_flags", 32'(out_flags), 32'(e.fl));
            end
            if (in_valid && in_ready) begin
                e     = cur;
                e.acc = cyc + 1;
                sb.push_back(e);
            end
            prev_v = out_valid;
        end
    end

    task automatic issue(input logic [31:0] x, input logic [TW-1:0] tag);
        bit done;
        done = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_x     = x;
        in_tag   = tag;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1;
        end
        if (!done) begin
            n_chk++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 for 20 cycles, want accept of %h", x);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic set_cur(input logic [31:0] y, input logic [TW-1:0] tag,
                           input logic [1:0] fl, input int lat);
        cur.y   = y;
        cur.tag = tag;
        cur.fl  = fl;
        cur.acc = 0;
        cur.lat = lat;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clk);
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("valid_seen", 32'(seen), 32'd1);
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{32'h4080_0000, 4'h3, 32'h4000_0000, 2'b00, LAT};
        vecs[1]  = '{32'h4000_0000, 4'h5, 32'h3FB5_04F3, 2'b00, LAT};
        vecs[2]  = '{32'hBF80_0000, 4'h6, 32'hFFC0_0000, 2'b10, 1};
        vecs[3]  = '{32'h8000_0000, 4'h7, 32'h8000_0000, 2'b00, 1};
        vecs[4]  = '{32'h7F80_0000, 4'h8, 32'h7F80_0000, 2'b00, 1};
        vecs[5]  = '{32'h7F80_0001, 4'h9, 32'h7FC0_0001, 2'b11, 1};
        vecs[6]  = '{32'h7FC0_0000, 4'hA, 32'h7FC0_0000, 2'b01, 1};
        vecs[7]  = '{32'h0000_0000, 4'hB, 32'h0000_0000, 2'b00, 1};
        vecs[8]  = '{32'hFF80_0000, 4'hC, 32'hFFC0_0000, 2'b10, 1};
        vecs[9]  = '{32'hFFA0_0000, 4'hD, 32'hFFE0_0000, 2'b11, 1};
        vecs[10] = '{32'h3F80_0000, 4'hE, 32'h3F80_0000, 2'b00, LAT};
        vecs[11] = '{32'h4110_0000, 4'hF, 32'h4040_0000, 2'b00, LAT};
        vecs[12] = '{32'h3E80_0000, 4'h0, 32'h3F00_0000, 2'b00, LAT};
        vecs[13] = '{32'h0020_0000, 4'h1, 32'h1F80_0000, 2'b00, LAT};
        vecs[14] = '{32'h7F7F_FFFF, 4'h2, 32'h5F7F_FFFF, 2'b00, LAT};
        vecs[15] = '{32'h4010_0000, 4'h4, 32'h3FC0_0000, 2'b00, LAT};

        // Reset state.
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Table vectors streamed back-to-back with out_ready held high.
        for (int i = 0; i < 16; i++) begin
            set_cur(vecs[i].y, vecs[i].tag, vecs[i].fl, vecs[i].lat);
            issue(vecs[i].x, vecs[i].tag);
        end
        wait_drain();

        // Backpressure: result held while a second operand waits.
        @(posedge clk);
        #1 out_ready = 1'b0;
        set_cur(32'h4080_0000, 4'h5, 2'b00, LAT);
        issue(32'h4180_0000, 4'h5);
        wait_valid();
        set_cur(32'h3FC0_0000, 4'h6, 2'b00, LAT);
        fork
            issue(32'h4010_0000, 4'h6);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_out_valid", 32'(out_valid), 32'd1);
                    chk("bp_out_y", out_y, 32'h4080_0000);
                    chk("bp_out_tag", 32'(out_tag), 32'h5);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset while a result is held: out_valid must fall without a clock.
        @(posedge clk);
        #1 out_ready = 1'b0;
        set_cur(32'h3F80_0000, 4'h9, 2'b00, LAT);
        issue(32'h3F80_0000, 4'h9);
        wait_valid();
        #1 rst = 1'b1;
        sb.delete();
        #1 chk("async_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // Reset in the second WAIT cycle aborts the operation.
        set_cur(32'h4040_0000, 4'h7, 2'b00, LAT);
        issue(32'h4110_0000, 4'h7);
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (LAT + 3) begin
            @(negedge clk);
            chk("abort_out_valid", 32'(out_valid), 32'd0);
            chk("abort_in_ready", 32'(in_ready), 32'd1);
        end

        // Recovery after abort.
        set_cur(32'h4000_0000, 4'h8, 2'b00, LAT);
        issue(32'h4080_0000, 4'h8);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish before 200000");
        $fatal(1);
    end
endmodule

`default_nettype wire
